// File: rtl/rob_param.sv
// rob_param: tag-addressed reorder buffer with alloc (alloc_*), NUM_WB writeback ports (wb_*), in-order commit (commit_*), exception/flush (exc_*, flush) and occupancy (count, empty, full)
module rob_param #(
  parameter int DEPTH = 32,
  parameter int DATA_W = 32,
  parameter int NUM_WB = 4,
  parameter int CAUSE_W = 2,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic [4:0]                 alloc_rd,
  input  logic                       alloc_reg_write,
  input  logic                       alloc_mem_write,
  input  logic                       alloc_exc,
  input  logic [CAUSE_W-1:0]         alloc_cause,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_WB-1:0]          wb_exc,
  input  logic [NUM_WB*CAUSE_W-1:0]  wb_cause,
  output logic                       commit_valid,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [4:0]                 commit_rd,
  output logic [DATA_W-1:0]          commit_data,
  output logic [DATA_W-1:0]          commit_pc,
  output logic                       commit_reg_write,
  output logic                       commit_mem_write,
  output logic                       exc_valid,
  output logic [DATA_W-1:0]          exc_pc,
  output logic [CAUSE_W-1:0]         exc_cause,
  output logic [TAG_W:0]             count,
  output logic                       empty,
  output logic                       full
);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] ONE = (TAG_W+1)'(1);
  logic [DEPTH-1:0] valid, ready, exc_q, rw_q, mw_q;
  logic [CAUSE_W-1:0] cause_q [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [DATA_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W:0] head, tail;
  logic [TAG_W-1:0] h;
  logic [TAG_W-1:0] wt [NUM_WB];
  logic head_rdy, head_exc, do_commit, do_alloc;
  for (genvar g = 0; g < NUM_WB; g++) begin : g_wt
    assign wt[g] = wb_tag[g*TAG_W +: TAG_W];
  end
  assign h = head[TAG_W-1:0];
  assign alloc_tag = tail[TAG_W-1:0];
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign alloc_ready = !full && !flush;
  assign head_rdy = valid[h] && ready[h];
  assign head_exc = head_rdy && exc_q[h];
  assign do_commit = head_rdy && !exc_q[h];
  assign do_alloc = alloc_valid && alloc_ready;
  always_ff @(posedge clk) begin
    commit_valid <= 1'b0;
    exc_valid <= 1'b0;
    if (rst) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      exc_pc <= '0;
      exc_cause <= '0;
      commit_tag <= '0;
      commit_rd <= '0;
      commit_data <= '0;
      commit_pc <= '0;
      commit_reg_write <= 1'b0;
      commit_mem_write <= 1'b0;
    end else if (flush || head_exc) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      if (!flush) begin
        exc_valid <= 1'b1;
        exc_pc <= pc_q[h];
        exc_cause <= cause_q[h];
      end
    end else begin
      for (int p = 0; p < NUM_WB; p++)
        if (wb_valid[p] && valid[wt[p]]) begin
          ready[wt[p]] <= 1'b1;
          data_q[wt[p]] <= wb_data[p*DATA_W +: DATA_W];
          exc_q[wt[p]] <= wb_exc[p];
          cause_q[wt[p]] <= wb_cause[p*CAUSE_W +: CAUSE_W];
        end
      if (do_alloc) begin
        valid[alloc_tag] <= 1'b1;
        ready[alloc_tag] <= alloc_exc;
        exc_q[alloc_tag] <= alloc_exc;
        cause_q[alloc_tag] <= alloc_cause;
        data_q[alloc_tag] <= '0;
        rd_q[alloc_tag] <= alloc_rd;
        rw_q[alloc_tag] <= alloc_reg_write;
        mw_q[alloc_tag] <= alloc_mem_write;
        pc_q[alloc_tag] <= alloc_pc;
        tail <= tail + ONE;
      end
      if (do_commit) begin
        valid[h] <= 1'b0;
        head <= head + ONE;
        commit_valid <= 1'b1;
        commit_tag <= h;
        commit_rd <= rd_q[h];
        commit_data <= data_q[h];
        commit_pc <= pc_q[h];
        commit_reg_write <= rw_q[h];
        commit_mem_write <= mw_q[h];
      end
      count <= do_alloc == do_commit ? count : do_alloc ? count + ONE : count - ONE;
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed table and sequence checks of rob_param at DEPTH=8, NUM_WB=4
module tb_rob_param;
  logic clk = 1'b0, rst = 1'b1, flush;
  logic alloc_valid, alloc_ready, alloc_reg_write, alloc_mem_write, alloc_exc;
  logic [2:0] alloc_tag;
  logic [31:0] alloc_pc;
  logic [4:0] alloc_rd;
  logic [1:0] alloc_cause;
  logic [3:0] wb_valid, wb_exc;
  logic [11:0] wb_tag;
  logic [127:0] wb_data;
  logic [7:0] wb_cause;
  logic commit_valid, commit_reg_write, commit_mem_write, exc_valid, empty, full;
  logic [2:0] commit_tag;
  logic [4:0] commit_rd;
  logic [31:0] commit_data, commit_pc, exc_pc;
  logic [1:0] exc_cause;
  logic [3:0] count;
  int total = 0, bad = 0;
  typedef struct {
    logic fl; logic av; logic [31:0] apc; logic aexc; logic [1:0] acause;
    logic wv; int wp; logic [2:0] wt; logic [31:0] wd; logic we; logic [1:0] wc;
    int e_cnt; logic e_cv; logic [2:0] e_tag; logic [31:0] e_data;
    logic e_ev; logic [31:0] e_epc; logic [1:0] e_ec;
  } vec_t;
  vec_t vt [23];
  logic [31:0] coll_d [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h44, 32'hBB};
  rob_param #(.DEPTH(8), .DATA_W(32), .NUM_WB(4), .CAUSE_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_pc(alloc_pc), .alloc_rd(alloc_rd), .alloc_reg_write(alloc_reg_write),
    .alloc_mem_write(alloc_mem_write), .alloc_exc(alloc_exc), .alloc_cause(alloc_cause),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc), .wb_cause(wb_cause),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_pc(commit_pc), .commit_reg_write(commit_reg_write),
    .commit_mem_write(commit_mem_write), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .exc_cause(exc_cause), .count(count), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    flush = 0; alloc_valid = 0; alloc_pc = 0; alloc_rd = 0; alloc_reg_write = 0;
    alloc_mem_write = 0; alloc_exc = 0; alloc_cause = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0; wb_exc = 0; wb_cause = 0;
  endtask
  task automatic alloc(input logic [31:0] pc);
    alloc_valid = 1; alloc_pc = pc;
  endtask
  task automatic wb(input int p, input int t, input logic [31:0] d, input logic e, input logic [1:0] c);
    logic [2:0] t3;
    t3 = 3'(t);
    wb_valid[p] = 1; wb_tag[p*3 +: 3] = t3; wb_data[p*32 +: 32] = d;
    wb_exc[p] = e; wb_cause[p*2 +: 2] = c;
  endtask
  task automatic do_rst();
    clr(); rst = 1; step(); rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int sa, sw, sc;
    vt[0]  = '{0,1,32'h200,0,0, 0,0,0,0,0,0, 1,0,0,0, 0,0,0};
    vt[1]  = '{0,1,32'h204,0,0, 0,0,0,0,0,0, 2,0,0,0, 0,0,0};
    vt[2]  = '{0,1,32'h208,0,0, 0,0,0,0,0,0, 3,0,0,0, 0,0,0};
    vt[3]  = '{0,0,0,0,0, 1,2,2,32'h30,0,0, 3,0,0,0, 0,0,0};
    vt[4]  = '{0,0,0,0,0, 1,1,1,32'h20,0,0, 3,0,0,0, 0,0,0};
    vt[5]  = '{0,0,0,0,0, 1,0,0,32'h10,0,0, 3,0,0,0, 0,0,0};
    vt[6]  = '{0,0,0,0,0, 0,0,0,0,0,0, 2,1,0,32'h10, 0,0,0};
    vt[7]  = '{0,0,0,0,0, 0,0,0,0,0,0, 1,1,1,32'h20, 0,0,0};
    vt[8]  = '{0,0,0,0,0, 0,0,0,0,0,0, 0,1,2,32'h30, 0,0,0};
    vt[9]  = '{1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0};
    vt[10] = '{0,1,32'h100,0,0, 0,0,0,0,0,0, 1,0,0,0, 0,0,0};
    vt[11] = '{0,1,32'h104,0,0, 0,0,0,0,0,0, 2,0,0,0, 0,0,0};
    vt[12] = '{0,1,32'h108,0,0, 0,0,0,0,0,0, 3,0,0,0, 0,0,0};
    vt[13] = '{0,1,32'h10C,0,0, 0,0,0,0,0,0, 4,0,0,0, 0,0,0};
    vt[14] = '{0,0,0,0,0, 1,3,1,32'h99,1,2, 4,0,0,0, 0,0,0};
    vt[15] = '{0,0,0,0,0, 1,0,0,32'h55,0,0, 4,0,0,0, 0,0,0};
    vt[16] = '{0,0,0,0,0, 0,0,0,0,0,0, 3,1,0,32'h55, 0,0,0};
    vt[17] = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 1,32'h104,2};
    vt[18] = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0};
    vt[19] = '{0,0,0,0,0, 1,0,2,32'h66,0,0, 0,0,0,0, 0,0,0};
    vt[20] = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0};
    vt[21] = '{0,1,32'h300,1,1, 0,0,0,0,0,0, 1,0,0,0, 0,0,0};
    vt[22] = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 1,32'h300,1};
    do_rst();
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_ev", 32'(exc_valid), 0);
    chk("rst_epc", exc_pc, 0);
    chk("rst_cdata", commit_data, 0);
    for (int i = 0; i < 23; i++) begin
      clr();
      flush = vt[i].fl; alloc_valid = vt[i].av; alloc_pc = vt[i].apc;
      alloc_exc = vt[i].aexc; alloc_cause = vt[i].acause;
      if (vt[i].wv) wb(vt[i].wp, 32'(vt[i].wt), vt[i].wd, vt[i].we, vt[i].wc);
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_cnt == 0));
      chk($sformatf("v%0d_cv", i), 32'(commit_valid), 32'(vt[i].e_cv));
      chk($sformatf("v%0d_ev", i), 32'(exc_valid), 32'(vt[i].e_ev));
      if (vt[i].e_cv) begin
        chk($sformatf("v%0d_ctag", i), 32'(commit_tag), 32'(vt[i].e_tag));
        chk($sformatf("v%0d_cdata", i), commit_data, vt[i].e_data);
      end
      if (vt[i].e_ev) begin
        chk($sformatf("v%0d_epc", i), exc_pc, vt[i].e_epc);
        chk($sformatf("v%0d_ecause", i), 32'(exc_cause), 32'(vt[i].e_ec));
      end
    end
    do_rst();
    for (int k = 0; k < 8; k++) begin
      clr(); alloc(32'h1000 + 32'(k*4)); alloc_rd = 5'(k+1); alloc_reg_write = 1'(k); step();
    end
    clr();
    chk("fill_count", 32'(count), 8);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(alloc_ready), 0);
    alloc(32'h2000); step();
    chk("fill_stall", 32'(count), 8);
    for (int k = 0; k < 8; k++) begin
      clr(); wb(0, k, 32'h700 + 32'(k), 0, 0); step();
      chk("drain_cv", 32'(commit_valid), 32'(k > 0));
      if (k > 0) begin
        chk("drain_tag", 32'(commit_tag), 32'(k-1));
        chk("drain_data", commit_data, 32'h700 + 32'(k-1));
        chk("drain_rd", 32'(commit_rd), 32'(k));
        chk("drain_pc", commit_pc, 32'h1000 + 32'((k-1)*4));
      end
    end
    clr(); step();
    chk("drain_last_cv", 32'(commit_valid), 1);
    chk("drain_last_tag", 32'(commit_tag), 7);
    chk("drain_empty", 32'(empty), 1);
    step();
    chk("drain_after_cv", 32'(commit_valid), 0);
    do_rst();
    for (int k = 0; k < 6; k++) begin
      clr(); alloc(32'(k)); step();
    end
    clr();
    for (int p = 0; p < 4; p++) wb(p, p, coll_d[p], 0, 0);
    step();
    chk("coll_cv0", 32'(commit_valid), 0);
    clr(); wb(0, 4, 32'h44, 0, 0); wb(1, 5, 32'hAA, 0, 0); wb(3, 5, 32'hBB, 0, 0); step();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin clr(); step(); end
      chk("coll_cv", 32'(commit_valid), 1);
      chk("coll_tag", 32'(commit_tag), 32'(k));
      chk("coll_data", commit_data, coll_d[k]);
    end
    chk("coll_empty", 32'(empty), 1);
    do_rst();
    sa = 0; sw = 0; sc = 0;
    for (int k = 0; k < 7; k++) begin
      clr(); alloc(32'(sa)); sa++; step();
    end
    clr(); wb(0, sw % 8, 32'h5000 + 32'(sw), 0, 0); sw++; step();
    chk("wrap_pre_cv", 32'(commit_valid), 0);
    for (int i = 0; i < 24; i++) begin
      clr();
      chk("wrap_atag", 32'(alloc_tag), 32'(sa % 8));
      alloc(32'(sa)); sa++;
      wb(0, sw % 8, 32'h5000 + 32'(sw), 0, 0); sw++;
      step();
      chk("wrap_cv", 32'(commit_valid), 1);
      if (commit_valid) begin
        chk("wrap_tag", 32'(commit_tag), 32'(sc % 8));
        chk("wrap_data", commit_data, 32'h5000 + 32'(sc));
        sc++;
      end
      chk("wrap_count", 32'(count), 7);
      chk("wrap_full", 32'(full), 0);
      chk("wrap_empty", 32'(empty), 0);
    end
    for (int i = 0; i < 16 && (sw < sa || count != 0); i++) begin
      clr();
      if (sw < sa) begin wb(0, sw % 8, 32'h5000 + 32'(sw), 0, 0); sw++; end
      step();
      if (commit_valid) begin
        chk("wrap_dtag", 32'(commit_tag), 32'(sc % 8));
        chk("wrap_ddata", commit_data, 32'h5000 + 32'(sc));
        sc++;
      end
    end
    chk("wrap_commits", 32'(sc), 31);
    chk("wrap_end_empty", 32'(empty), 1);
    do_rst();
    for (int k = 0; k < 5; k++) begin
      clr(); alloc(32'h800 + 32'(k)); step();
    end
    clr(); alloc(32'h999); wb(0, 0, 32'h1, 0, 0); flush = 1; #1;
    chk("flush_ready", 32'(alloc_ready), 0);
    step();
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    clr(); wb(0, 1, 32'h2, 0, 0); step();
    chk("flush_cv1", 32'(commit_valid), 0);
    clr(); step();
    chk("flush_cv2", 32'(commit_valid), 0);
    chk("flush_count2", 32'(count), 0);
    clr(); alloc(32'h400); step();
    clr(); wb(0, 0, 32'h77, 0, 0); step();
    clr(); step();
    chk("post_cv", 32'(commit_valid), 1);
    chk("post_data", commit_data, 32'h77);
    clr(); alloc(32'h3AC); alloc_exc = 1; alloc_cause = 3; step();
    clr(); step();
    chk("dexc_ev", 32'(exc_valid), 1);
    chk("dexc_cv", 32'(commit_valid), 0);
    chk("dexc_pc", exc_pc, 32'h3AC);
    chk("dexc_cause", 32'(exc_cause), 3);
    clr(); flush = 1; step();
    chk("flush_keep_epc", exc_pc, 32'h3AC);
    chk("flush_ev", 32'(exc_valid), 0);
    clr(); rst = 1; step(); rst = 0;
    chk("rst2_epc", exc_pc, 0);
    chk("rst2_ecause", 32'(exc_cause), 0);
    chk("rst2_cdata", commit_data, 0);
    chk("rst2_cpc", commit_pc, 0);
    chk("rst2_count", 32'(count), 0);
    chk("rst2_ready", 32'(alloc_ready), 1);
    chk("rst2_empty", 32'(empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
